// File: rtl/fp32_cvt_pkg.sv
// Shared constants and FP32 field layout for the FP32 -> INT32 conversion slice.
package fp32_cvt_pkg;

  localparam logic [31:0] INT32_MAX = 32'h7FFFFFFF;
  localparam logic [31:0] INT32_MIN = 32'h80000000;

  localparam int FLAG_NV = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_NX = 0;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  // Biased exponent of 1.0, and of 2^31 (first magnitude that no longer fits)
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(EXP_BIAS);
  localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'(EXP_BIAS + 31);

  // -2^31.0 is the one saturating-range input that is exactly representable
  localparam logic [31:0] FP32_NEG_2P31 = 32'hCF000000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/fp32_to_int32.sv
// Combinational FP32 -> INT32 converter: round toward zero, NaN -> 0, saturating.
module fp32_to_int32
  import fp32_cvt_pkg::*;
(
  input  logic [31:0] operand,
  output logic [31:0] result
);

  fp32_t            f;
  logic [EXP_W-1:0] shift;
  logic [54:0]      wide;
  logic [31:0]      mag;

  assign f = operand;

  // Integer part is the significand shifted left by the unbiased exponent,
  // then the 23 fraction bits dropped; only used for exponents 0..30.
  always_comb begin
    shift  = f.exponent - EXP_ONE;
    wide   = {31'b0, 1'b1, f.man} << shift;
    mag    = wide[54:23];
    result = '0;
    if (f.exponent == '1) begin
      result = (|f.man) ? '0 : (f.sign ? INT32_MIN : INT32_MAX);
    end else if (f.exponent < EXP_ONE) begin
      result = '0;
    end else if (f.exponent >= EXP_SAT) begin
      result = f.sign ? INT32_MIN : INT32_MAX;
    end else begin
      result = f.sign ? -mag : mag;
    end
  end

endmodule

// File: rtl/fp32_to_int32_rr_arb.sv
// Round-robin grant over NUM_REQ requesters; priority pointer moves past the winner on advance.
module fp32_to_int32_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   idx;

  // Scan from the farthest offset down so the nearest valid requester to ptr wins last.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (ID_W + 1)'(k);
      if (idx >= (ID_W + 1)'(NUM_REQ)) begin
        idx = idx - (ID_W + 1)'(NUM_REQ);
      end
      if (valid[idx[ID_W-1:0]]) begin
        grant_id    = idx[ID_W-1:0];
        grant_valid = 1'b1;
      end
    end
    if (grant_valid) begin
      grant[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/fp32_to_int32_arb.sv
// Shared FP32 -> INT32 converter with round-robin request arbitration and a 2-stage pipeline.
// Build with FP32_CVT_FLAGS_EN to add the {NV, OF, NX} rsp_flags output.
module fp32_to_int32_arb
  import fp32_cvt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
`ifdef FP32_CVT_FLAGS_EN
  output logic [ID_W-1:0]       rsp_id,
  output logic [2:0]            rsp_flags
`else
  output logic [ID_W-1:0]       rsp_id
`endif
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;
  logic [31:0]        grant_data;

  logic               s1_valid;
  logic [31:0]        s1_data;
  logic [ID_W-1:0]    s1_id;
  logic [31:0]        cvt_result;

  logic               s1_load;
  logic               s2_load;

  assign s2_load   = !rsp_valid | rsp_ready;
  assign s1_load   = !s1_valid | s2_load;
  assign req_ready = rst ? '0 : (grant & {NUM_REQ{s1_load}});

  fp32_to_int32_rr_arb #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid      (req_valid),
    .advance    (s1_load & grant_valid),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_data = req_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
    end else if (s1_load) begin
      s1_valid <= grant_valid;
      s1_data  <= grant_data;
      s1_id    <= grant_id;
    end
  end

  fp32_to_int32 u_cvt (
    .operand(s1_data),
    .result (cvt_result)
  );

  // Payload only moves on a real result so a bubble leaves the last value parked.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (s2_load) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_data <= cvt_result;
        rsp_id   <= s1_id;
      end
    end
  end

`ifdef FP32_CVT_FLAGS_EN
  fp32_t            s1_f;
  logic [EXP_W-1:0] s1_shift;
  logic [2:0]       s1_flags;
  logic             is_nan;
  logic             is_inf;

  assign s1_f     = s1_data;
  assign s1_shift = s1_f.exponent - EXP_ONE;
  assign is_nan   = (s1_f.exponent == '1) &&  (|s1_f.man);
  assign is_inf   = (s1_f.exponent == '1) && !(|s1_f.man);

  // Inexact only for in-range values: fraction bits below the binary point are nonzero.
  always_comb begin
    s1_flags          = '0;
    s1_flags[FLAG_NV] = is_nan;
    s1_flags[FLAG_OF] = is_inf ||
                        ((s1_f.exponent != '1) && (s1_f.exponent >= EXP_SAT) &&
                         (s1_data != FP32_NEG_2P31));
    if (s1_f.exponent < EXP_ONE) begin
      s1_flags[FLAG_NX] = |{s1_f.exponent, s1_f.man};
    end else if (s1_f.exponent < EXP_SAT) begin
      s1_flags[FLAG_NX] = |(s1_f.man & ({MAN_W{1'b1}} >> s1_shift));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_flags <= '0;
    end else if (s2_load && s1_valid) begin
      rsp_flags <= s1_flags;
    end
  end
`endif

endmodule

// File: tb/tb_fp32_to_int32_arb.sv
// Directed self-checking bench for fp32_to_int32_arb (flags checked when FP32_CVT_FLAGS_EN is defined).
module tb_fp32_to_int32_arb;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_data = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
`ifdef FP32_CVT_FLAGS_EN
  logic [2:0]            rsp_flags;
`endif

  logic [31:0] laneData [NUM_REQ];
  int          checkCount = 0;
  int          failCount  = 0;

  fp32_to_int32_arb #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
`ifdef FP32_CVT_FLAGS_EN
    .rsp_id   (rsp_id),
    .rsp_flags(rsp_flags)
`else
    .rsp_id   (rsp_id)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid);
    for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = laneData[i];
    req_valid = valid;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0);
    tick();
    tick();
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 0);
    applyStimulus('1);
    checkOutput("rst_req_ready", 32'(req_ready), 0);
    applyStimulus('0);
    rst = 1'b0;
  endtask

  task automatic sendOne(input string tag, input int lane, input logic [31:0] data,
                         input logic [31:0] expData, input logic [2:0] expFlags);
    laneData[lane] = data;
    applyStimulus(NUM_REQ'(1 << lane));
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1 << lane));
    tick();
    applyStimulus('0);
    checkOutput({tag, "_early"}, 32'(rsp_valid), 0);
    tick();
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 1);
    checkOutput({tag, "_data"}, rsp_data, expData);
    checkOutput({tag, "_id"}, 32'(rsp_id), 32'(lane));
`ifdef FP32_CVT_FLAGS_EN
    checkOutput({tag, "_flags"}, 32'(rsp_flags), 32'(expFlags));
`else
    if (expFlags > 3'd7) checkOutput({tag, "_flags"}, 32'(expFlags), 0);
`endif
    tick();
  endtask

  initial begin
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] accepted;
    int                 acceptTotal;
    int                 got;
    logic [31:0]        expVals [NUM_REQ];

    for (int i = 0; i < NUM_REQ; i++) laneData[i] = '0;
    expVals[0] = 32'd10; expVals[1] = 32'd20; expVals[2] = 32'd30; expVals[3] = 32'd40;
    doReset();

    // Single conversions and special values, flags {NV,OF,NX}
    sendOne("cvt_3p7",    1, 32'h406CCCCD, 32'd3,        3'b001);
    sendOne("cvt_nan",    2, 32'h7FC00000, 32'd0,        3'b100);
    sendOne("cvt_2p31",   3, 32'h4F000000, 32'h7FFFFFFF, 3'b010);
    sendOne("cvt_m2p31",  0, 32'hCF000000, 32'h80000000, 3'b000);
    sendOne("cvt_minf",   1, 32'hFF800000, 32'h80000000, 3'b010);
    sendOne("cvt_pinf",   2, 32'h7F800000, 32'h7FFFFFFF, 3'b010);
    sendOne("cvt_below",  3, 32'hCF000001, 32'h80000000, 3'b010);
    sendOne("cvt_m1p5",   0, 32'hBFC00000, 32'hFFFFFFFF, 3'b001);
    sendOne("cvt_0p5",    1, 32'h3F000000, 32'd0,        3'b001);
    sendOne("cvt_subn",   2, 32'h00000001, 32'd0,        3'b001);
    sendOne("cvt_zero",   3, 32'h00000000, 32'd0,        3'b000);
    sendOne("cvt_one",    0, 32'h3F800000, 32'd1,        3'b000);
    sendOne("cvt_maxfin", 1, 32'h4EFFFFFF, 32'h7FFFFF80, 3'b000);
    sendOne("cvt_m100",   2, 32'hC2C80000, 32'hFFFFFF9C, 3'b000);

    // Fairness: all lanes held valid from a fresh pointer
    $display("[TB] fairness");
    doReset();
    laneData[0] = 32'h41200000; laneData[1] = 32'h41A00000;
    laneData[2] = 32'h41F00000; laneData[3] = 32'h42200000;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(k < 8 ? 4'hF : 4'h0);
      if (k < 8) checkOutput("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        checkOutput("fair_valid", 32'(rsp_valid), 1);
        checkOutput("fair_id", 32'(rsp_id), 32'((k - 2) % 4));
        checkOutput("fair_data", rsp_data, expVals[(k - 2) % 4]);
      end
      tick();
    end
    checkOutput("fair_drained", 32'(rsp_valid), 0);

    // Backpressure: two in flight, then everything blocked until release
    $display("[TB] backpressure");
    doReset();
    rsp_ready   = 1'b0;
    pending     = 4'hF;
    acceptTotal = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(pending);
      accepted = req_valid & req_ready;
      acceptTotal += $countones(accepted);
      if (c >= 2) begin
        checkOutput("bp_ready", 32'(req_ready), 0);
        checkOutput("bp_hold_valid", 32'(rsp_valid), 1);
        checkOutput("bp_hold_id", 32'(rsp_id), 0);
        checkOutput("bp_hold_data", rsp_data, 32'd10);
      end
      tick();
      pending &= ~accepted;
    end
    checkOutput("bp_accepted", 32'(acceptTotal), 2);
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(pending);
      accepted = req_valid & req_ready;
      if (rsp_valid) begin
        if (got < NUM_REQ) begin
          checkOutput("bp_order_id", 32'(rsp_id), 32'(got));
          checkOutput("bp_order_data", rsp_data, expVals[got]);
        end else begin
          checkOutput("bp_extra", 32'(rsp_valid), 0);
        end
        got++;
      end
      tick();
      pending &= ~accepted;
    end
    checkOutput("bp_count", 32'(got), 4);

    // Reset with both stages full
    $display("[TB] reset mid-stream");
    doReset();
    rsp_ready = 1'b0;
    applyStimulus(4'hF);
    tick();
    applyStimulus(4'hE);
    tick();
    checkOutput("rm_full", 32'(rsp_valid), 1);
    rst = 1'b1;
    #1;
    checkOutput("rm_ready_in_rst", 32'(req_ready), 0);
    tick();
    checkOutput("rm_flushed", 32'(rsp_valid), 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    applyStimulus(4'hF);
    checkOutput("rm_first_grant", 32'(req_ready), 1);
    tick();
    applyStimulus(4'h0);
    checkOutput("rm_no_stale", 32'(rsp_valid), 0);
    tick();
    checkOutput("rm_valid", 32'(rsp_valid), 1);
    checkOutput("rm_id", 32'(rsp_id), 0);
    checkOutput("rm_data", rsp_data, 32'd10);
    tick();
    checkOutput("rm_idle", 32'(rsp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
